// File: rtl/dmem_pkg.sv
// Shared definitions for the DataMemory block mover: state encoding, mode constants and
// default port widths.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned DMEM_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_block_mover.sv
// Block COPY / FILL engine driving the DataMemory port. One FSM, one index counter and
// one data buffer; all outputs are decoded from registered state only.
module dmem_block_mover
    import dmem_pkg::*;
#(
    parameter int unsigned AW = DMEM_AW,
    parameter int unsigned DW = DMEM_DW,
    parameter int unsigned LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    input  logic [DW-1:0] fill_val,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] count,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [LW-1:0] FULL_LEN = LW'(1) << AW;

    state_e        state_q, state_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [LW-1:0] len_q, len_d;
    logic [DW-1:0] fill_q, fill_d;

    logic [LW-1:0] len_clamped;
    logic [LW-1:0] idx_inc;

    assign len_clamped = (len > FULL_LEN) ? FULL_LEN : len;
    assign idx_inc     = idx_q + LW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            mode_q  <= MODE_COPY;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        fill_d  = fill_q;

        unique case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (start && !abort) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    len_d  = len_clamped;
                    fill_d = fill_val;
                    idx_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = DONE;
                    end else if (mode == MODE_FILL) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                buf_d   = mem_dout;
                state_d = abort ? IDLE : WR;
            end
            WR: begin
                // the write of this cycle lands even when aborting, so it is counted
                idx_d = idx_inc;
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_inc == len_q) begin
                    state_d = DONE;
                end else if (mode_q == MODE_FILL) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;

        unique case (state_q)
            RD: begin
                busy     = 1'b1;
                mem_addr = src_q + idx_q[AW-1:0];
            end
            WR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = dst_q + idx_q[AW-1:0];
                mem_din  = (mode_q == MODE_FILL) ? fill_q : buf_q;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign count = idx_q;

endmodule

// File: tb/tb_dmem_block_mover.sv
// Directed bench for dmem_block_mover with a behavioural DataMemory responder.
module tb_dmem_block_mover;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] src_addr;
    logic [7:0] dst_addr;
    logic [8:0] len;
    logic [7:0] fill_val;
    logic       abort;
    logic       busy;
    logic       done;
    logic [8:0] count;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic [7:0] mem_dout;

    logic [7:0] mem [256];
    logic       tb_sel;
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_din;
    logic       m_we;
    logic [7:0] m_addr;
    logic [7:0] m_din;
    int         wr_cnt;

    int total;
    int bad;

    dmem_block_mover dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .fill_val (fill_val),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory: bench preloads through the same write port while the mover is idle
    assign m_we     = tb_sel ? tb_we : mem_we;
    assign m_addr   = tb_sel ? tb_addr : mem_addr;
    assign m_din    = tb_sel ? tb_din : mem_din;
    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (m_we) mem[m_addr] <= m_din;
    end

    initial wr_cnt = 0;
    always @(posedge clk) begin
        if (mem_we && !tb_sel) wr_cnt <= wr_cnt + 1;
    end

    function automatic logic [7:0] pat(input int i);
        return 8'(i) ^ 8'hC3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
        tb_sel  = 1'b1;
        tb_we   = 1'b1;
        tb_addr = a;
        tb_din  = d;
        tick();
        tb_we  = 1'b0;
        tb_sel = 1'b0;
    endtask

    // Called in an IDLE cycle; returns in cycle 1 after the start-sampling edge.
    task automatic start_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] l, input logic [7:0] f);
        mode     = m;
        src_addr = s;
        dst_addr = d;
        len      = l;
        fill_val = f;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Advances until done is seen; cyc = cycle index at which done was high, -1 on timeout.
    task automatic wait_done(input int first, output int cyc);
        cyc = -1;
        for (int c = first; c <= first + 600; c++) begin
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    int cyc;
    int w0;

    initial begin
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        fill_val = '0;
        abort    = 1'b0;
        tb_sel   = 1'b0;
        tb_we    = 1'b0;
        tb_addr  = '0;
        tb_din   = '0;

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        #4 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) mem_write(8'(i), pat(i));

        // 1: COPY 0x10 -> 0x80, 4 bytes
        mem_write(8'h10, 8'hAA);
        mem_write(8'h11, 8'hBB);
        mem_write(8'h12, 8'hCC);
        mem_write(8'h13, 8'hDD);
        w0 = wr_cnt;
        start_op(1'b0, 8'h10, 8'h80, 9'd4, 8'h00);
        check("copy_busy", 32'(busy), 32'd1);
        wait_done(1, cyc);
        check("copy_done_cyc", 32'(cyc), 32'd9);
        check("copy_count", 32'(count), 32'd4);
        tick();
        check("copy_idle_busy", 32'(busy), 32'd0);
        check("copy_idle_done", 32'(done), 32'd0);
        check("copy_m80", 32'(mem[8'h80]), 32'hAA);
        check("copy_m81", 32'(mem[8'h81]), 32'hBB);
        check("copy_m82", 32'(mem[8'h82]), 32'hCC);
        check("copy_m83", 32'(mem[8'h83]), 32'hDD);
        check("copy_m84", 32'(mem[8'h84]), 32'(pat(8'h84)));
        check("copy_writes", 32'(wr_cnt - w0), 32'd4);

        // 2: FILL with address wrap
        w0 = wr_cnt;
        start_op(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5A);
        wait_done(1, cyc);
        check("fill_done_cyc", 32'(cyc), 32'd4);
        check("fill_count", 32'(count), 32'd3);
        tick();
        check("fill_mFE", 32'(mem[8'hFE]), 32'h5A);
        check("fill_mFF", 32'(mem[8'hFF]), 32'h5A);
        check("fill_m00", 32'(mem[8'h00]), 32'h5A);
        check("fill_m01", 32'(mem[8'h01]), 32'(pat(1)));
        check("fill_writes", 32'(wr_cnt - w0), 32'd3);

        // 3: zero length
        w0 = wr_cnt;
        start_op(1'b0, 8'h10, 8'h90, 9'd0, 8'h00);
        wait_done(1, cyc);
        check("zero_done_cyc", 32'(cyc), 32'd1);
        check("zero_count", 32'(count), 32'd0);
        tick();
        check("zero_writes", 32'(wr_cnt - w0), 32'd0);

        // 4: abort in the third WR cycle of an 8-byte COPY
        w0 = wr_cnt;
        start_op(1'b0, 8'h40, 8'hA0, 9'd8, 8'h00);
        repeat (5) tick();
        check("abort_in_wr", 32'(mem_we), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd3);
        tick();
        check("abort_done2", 32'(done), 32'd0);
        check("abort_writes", 32'(wr_cnt - w0), 32'd3);
        check("abort_mA2", 32'(mem[8'hA2]), 32'(pat(8'h42)));
        check("abort_mA3", 32'(mem[8'hA3]), 32'(pat(8'hA3)));

        // 5: async reset during a WR cycle
        start_op(1'b0, 8'h50, 8'hB0, 9'd4, 8'h00);
        tick();
        check("rst5_in_wr", 32'(mem_we), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst5_we", 32'(mem_we), 32'd0);
        check("rst5_addr", 32'(mem_addr), 32'd0);
        check("rst5_din", 32'(mem_din), 32'd0);
        check("rst5_busy", 32'(busy), 32'd0);
        check("rst5_count", 32'(count), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("rst5_mB0", 32'(mem[8'hB0]), 32'(pat(8'hB0)));
        start_op(1'b1, 8'h00, 8'hC0, 9'd2, 8'h77);
        wait_done(1, cyc);
        check("rst5_fresh_cyc", 32'(cyc), 32'd3);
        tick();
        check("rst5_mC1", 32'(mem[8'hC1]), 32'h77);

        // 6: overlapping forward COPY; starts while busy and in DONE are ignored
        mem_write(8'h20, 8'h11);
        w0 = wr_cnt;
        start_op(1'b0, 8'h20, 8'h21, 9'd3, 8'h00);
        tick();
        start_op(1'b1, 8'h00, 8'h00, 9'd1, 8'hEE);
        wait_done(3, cyc);
        check("ovl_done_cyc", 32'(cyc), 32'd7);
        check("ovl_count", 32'(count), 32'd3);
        start_op(1'b1, 8'h00, 8'h00, 9'd2, 8'hEE);
        check("ovl_start_in_done", 32'(busy), 32'd0);
        check("ovl_m21", 32'(mem[8'h21]), 32'h11);
        check("ovl_m22", 32'(mem[8'h22]), 32'h11);
        check("ovl_m23", 32'(mem[8'h23]), 32'h11);
        check("ovl_m24", 32'(mem[8'h24]), 32'(pat(8'h24)));
        check("ovl_writes", 32'(wr_cnt - w0), 32'd3);

        // 7: abort and start together in IDLE
        abort = 1'b1;
        start_op(1'b1, 8'h00, 8'h00, 9'd5, 8'hEE);
        abort = 1'b0;
        check("absta_busy", 32'(busy), 32'd0);
        check("absta_count", 32'(count), 32'd3);

        // 8: over-long FILL clamps to the whole memory
        w0 = wr_cnt;
        start_op(1'b1, 8'h00, 8'h00, 9'd300, 8'hE7);
        wait_done(1, cyc);
        check("clamp_done_cyc", 32'(cyc), 32'd257);
        check("clamp_count", 32'(count), 32'd256);
        tick();
        check("clamp_writes", 32'(wr_cnt - w0), 32'd256);
        check("clamp_m00", 32'(mem[8'h00]), 32'hE7);
        check("clamp_mFF", 32'(mem[8'hFF]), 32'hE7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
